// File: rtl/parity_link_pkg.sv
// Shared definitions for the XOR-parity serial link: receiver FSM states,
// parity-sense selectors and the idle line level.
package parity_link_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    localparam logic EVEN_PARITY = 1'b0;
    localparam logic ODD_PARITY  = 1'b1;
    localparam logic LINE_IDLE   = 1'b1;

endpackage

// File: rtl/serial_parity_rx_if.sv
// Bit-strobe input and received-word outputs of the parity link receiver.
interface serial_parity_rx_if #(
    parameter int DATA_W = 8
) ();

    logic              bit_vld;
    logic              rx_bit;
    logic [DATA_W-1:0] data_out;
    logic              data_vld;
    logic              parity_err;
    logic              frame_err;
    logic              busy;

    modport master (
        output bit_vld, rx_bit,
        input  data_out, data_vld, parity_err, frame_err, busy
    );

    modport slave (
        input  bit_vld, rx_bit,
        output data_out, data_vld, parity_err, frame_err, busy
    );

endinterface

// File: rtl/parity_acc.sv
// 1-bit running XOR accumulator with synchronous clear (priority) and enable;
// shared by the link receiver and transmitter parity logic.
module parity_acc (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    input  logic din,
    output logic acc
);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= 1'b0;
        end else if (clr) begin
            acc <= 1'b0;
        end else if (en) begin
            acc <= acc ^ din;
        end
    end

endmodule

// File: rtl/serial_parity_rx.sv
// Parity link receiver: frames start / DATA_W data bits (LSB first) / parity /
// stop from strobed line bits and reports the word with parity/framing flags.
module serial_parity_rx
    import parity_link_pkg::*;
#(
    parameter int   DATA_W = 8,
    parameter logic ODD    = EVEN_PARITY
) (
    input logic               clk,
    input logic               rst_n,
    serial_parity_rx_if.slave bus
);

    localparam int              CNT_W    = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    rx_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] shift_q, shift_next, data_q;
    logic              perr_q, parity_err_q, frame_err_q, data_vld_q;
    logic              strobe, start_bit, acc, acc_en;

    assign strobe    = bus.bit_vld;
    assign start_bit = strobe && (state_q == IDLE) && (bus.rx_bit != LINE_IDLE);
    assign acc_en    = strobe && (state_q == DATA);

    // Right shift: the first data bit received ends up at bit 0.
    if (DATA_W == 1) begin : g_shift_one
        assign shift_next = bus.rx_bit;
    end else begin : g_shift_many
        assign shift_next = {bus.rx_bit, shift_q[DATA_W-1:1]};
    end

    parity_acc u_parity_acc (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start_bit),
        .en    (acc_en),
        .din   (bus.rx_bit),
        .acc   (acc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: default first so no path through this block infers a latch.
        state_d = state_q;
        if (strobe) begin
            unique case (state_q)
                IDLE:    if (start_bit) state_d = DATA;
                DATA:    if (cnt_q == LAST_BIT) state_d = PARITY;
                PARITY:  state_d = STOP;
                STOP:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: the shift register and capture word are plain flops, not a RAM,
    // so they are reset along with the control state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            shift_q      <= '0;
            perr_q       <= 1'b0;
            data_q       <= '0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            data_vld_q   <= 1'b0;
        end else begin
            data_vld_q <= strobe && (state_q == STOP);
            if (strobe) begin
                unique case (state_q)
                    IDLE: begin
                        if (start_bit) cnt_q <= '0;
                    end
                    DATA: begin
                        shift_q <= shift_next;
                        cnt_q   <= cnt_q + CNT_W'(1);
                    end
                    PARITY: begin
                        perr_q <= acc ^ bus.rx_bit ^ ODD;
                    end
                    STOP: begin
                        // Data and parity result are delivered even on a bad stop bit.
                        data_q       <= shift_q;
                        parity_err_q <= perr_q;
                        frame_err_q  <= ~bus.rx_bit;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.data_out   = data_q;
    assign bus.data_vld   = data_vld_q;
    assign bus.parity_err = parity_err_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.busy       = (state_q != IDLE);

endmodule
